// File: rtl/stv_gray_tracker.sv
`default_nettype none
// ============================================================================
// Module      : stv_gray_tracker
// Description : Receive-side tracker for a gray-coded count. Checks that
//               consecutive samples differ by at most one bit, decodes to
//               binary, emits up/down/wrap/error pulses and keeps an
//               unwrapped POS_WIDTH-bit position. Locks after LOCK_CNT
//               consecutive valid steps.
//               Optional feature macro: STV_GRAY_TRACKER_ERR_CNT_EN
//               (adds err_cnt, a saturating 8-bit error counter).
// Revision    : 1.0 - initial release
// ============================================================================
module stv_gray_tracker #(
    parameter int WIDTH     = 5,
    parameter int POS_WIDTH = 16,
    parameter int LOCK_CNT  = 2
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 clear,
    input  logic                 en,
    input  logic [WIDTH-1:0]     gray_in,
    output logic [WIDTH-1:0]     bin_out,
    output logic [POS_WIDTH-1:0] pos,
    output logic                 step_up,
    output logic                 step_dn,
    output logic                 wrap,
    output logic                 err,
    output logic                 locked
`ifdef STV_GRAY_TRACKER_ERR_CNT_EN
    ,
    output logic [7:0]           err_cnt
`endif
);

    localparam int LCW = $clog2(LOCK_CNT + 1);

    localparam logic [1:0] S_UNLOCKED = 2'd0;
    localparam logic [1:0] S_ACQUIRE  = 2'd1;
    localparam logic [1:0] S_LOCKED   = 2'd2;

    localparam logic [WIDTH-1:0]     C_W_ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0]     C_W_ONES  = {WIDTH{1'b1}};
    localparam logic [POS_WIDTH-1:0] C_POS_ONE = POS_WIDTH'(1);
    localparam logic [LCW-1:0]       C_LOCK    = LCW'(LOCK_CNT);

    logic [1:0]           r_state;
    logic [WIDTH-1:0]     r_ref;
    logic [WIDTH-1:0]     r_bin;
    logic [POS_WIDTH-1:0] r_pos;
    logic [LCW-1:0]       r_lock_cnt;
    logic                 r_step_up;
    logic                 r_step_dn;
    logic                 r_wrap;
    logic                 r_err;

    logic [WIDTH-1:0]     w_bin;
    logic [WIDTH-1:0]     w_diff;
    logic                 w_d0;
    logic                 w_d1;
    logic                 w_dmulti;
    logic                 w_up;
    logic [LCW-1:0]       w_cnt_inc;

    // Gray to binary decode: each binary bit is the xor of all gray bits at or above it
    always_comb begin
        w_bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_bin[i] = ^(gray_in >> i);
        end
    end

    // Hamming-distance classification against the reference and step direction
    always_comb begin
        w_diff    = gray_in ^ r_ref;
        w_d0      = (w_diff == '0);
        w_d1      = !w_d0 && ((w_diff & (w_diff - C_W_ONE)) == '0);
        w_dmulti  = !w_d0 && !w_d1;
        w_up      = (w_bin == (r_bin + C_W_ONE));
        w_cnt_inc = r_lock_cnt + LCW'(1);
    end

    // Tracking state, reference sample, position and single-cycle pulses
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state    <= S_UNLOCKED;
            r_ref      <= '0;
            r_bin      <= '0;
            r_pos      <= '0;
            r_lock_cnt <= '0;
            r_step_up  <= 1'b0;
            r_step_dn  <= 1'b0;
            r_wrap     <= 1'b0;
            r_err      <= 1'b0;
        end else if (clear) begin
            r_state    <= S_UNLOCKED;
            r_ref      <= '0;
            r_bin      <= '0;
            r_pos      <= '0;
            r_lock_cnt <= '0;
            r_step_up  <= 1'b0;
            r_step_dn  <= 1'b0;
            r_wrap     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_step_up <= 1'b0;
            r_step_dn <= 1'b0;
            r_wrap    <= 1'b0;
            r_err     <= 1'b0;
            if (en) begin
                if (r_state == S_UNLOCKED) begin
                    // First sample only establishes the reference
                    r_ref      <= gray_in;
                    r_bin      <= w_bin;
                    r_lock_cnt <= '0;
                    r_state    <= S_ACQUIRE;
                end else if (w_d1) begin
                    r_ref <= gray_in;
                    r_bin <= w_bin;
                    if (w_up) begin
                        r_step_up <= 1'b1;
                        r_wrap    <= (r_bin == C_W_ONES);
                        r_pos     <= r_pos + C_POS_ONE;
                    end else begin
                        r_step_dn <= 1'b1;
                        r_wrap    <= (r_bin == '0) && (w_bin == C_W_ONES);
                        r_pos     <= r_pos - C_POS_ONE;
                    end
                    if (r_state == S_ACQUIRE) begin
                        r_lock_cnt <= w_cnt_inc;
                        if (w_cnt_inc == C_LOCK) begin
                            r_state <= S_LOCKED;
                        end
                    end
                end else if (w_dmulti) begin
                    // Multi-bit jump: resynchronise on the new sample, drop lock
                    r_err      <= 1'b1;
                    r_ref      <= gray_in;
                    r_bin      <= w_bin;
                    r_lock_cnt <= '0;
                    r_state    <= S_ACQUIRE;
                end
            end
        end
    end

`ifdef STV_GRAY_TRACKER_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    // Saturating count of error pulses
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_err_cnt <= 8'd0;
        end else if (clear) begin
            r_err_cnt <= 8'd0;
        end else if (en && (r_state != S_UNLOCKED) && w_dmulti && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

    assign bin_out = r_bin;
    assign pos     = r_pos;
    assign step_up = r_step_up;
    assign step_dn = r_step_dn;
    assign wrap    = r_wrap;
    assign err     = r_err;
    assign locked  = (r_state == S_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_stv_gray_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_stv_gray_tracker
// Description : Scoreboard bench for stv_gray_tracker (WIDTH=3, POS_WIDTH=16,
//               LOCK_CNT=2). Directed scenarios followed by random stimulus;
//               expectations come from a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stv_gray_tracker;

    typedef struct packed {
        logic [2:0]  bin;
        logic [15:0] pos;
        logic        up;
        logic        dn;
        logic        wrap;
        logic        err;
        logic        lock;
        logic [7:0]  ecnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        clear = 1'b0;
    logic        en = 1'b0;
    logic [2:0]  gray_in = 3'd0;
    logic [2:0]  bin_out;
    logic [15:0] pos;
    logic        step_up, step_dn, wrap, err, locked;
    logic [7:0]  ecnt_act;

    stv_gray_tracker #(.WIDTH(3), .POS_WIDTH(16), .LOCK_CNT(2)) dut (
        .clk     (clk),
        .arst_n  (arst_n),
        .clear   (clear),
        .en      (en),
        .gray_in (gray_in),
        .bin_out (bin_out),
        .pos     (pos),
        .step_up (step_up),
        .step_dn (step_dn),
        .wrap    (wrap),
        .err     (err),
        .locked  (locked)
`ifdef STV_GRAY_TRACKER_ERR_CNT_EN
        ,
        .err_cnt (ecnt_act)
`endif
    );

`ifndef STV_GRAY_TRACKER_ERR_CNT_EN
    assign ecnt_act = 8'd0;
`endif

    always #5 clk = ~clk;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Behavioural model state
    bit tracking;
    bit m_locked;
    int m_ref;
    int m_bin;
    int m_pos;
    int m_steps;
    int m_ecnt;

    function automatic int g2b(input int g);
        for (int n = 0; n < 8; n++) begin
            if ((n ^ (n >> 1)) == g) return n;
        end
        return 0;
    endfunction

    function automatic int b2g(input int b);
        return (b ^ (b >> 1)) & 7;
    endfunction

    task automatic model_reset();
        tracking = 0; m_locked = 0; m_ref = 0; m_bin = 0;
        m_pos = 0; m_steps = 0; m_ecnt = 0;
    endtask

    // One clock of stimulus; model result is queued for the monitor
    task automatic cyc(input bit a, input bit c, input bit e, input int g);
        exp_t x;
        int   d, b;
        @(negedge clk);
        arst_n = a; clear = c; en = e; gray_in = 3'(g);
        x = '0;
        if (!a || c) begin
            model_reset();
        end else if (e) begin
            b = g2b(g);
            if (!tracking) begin
                tracking = 1; m_ref = g; m_bin = b; m_steps = 0; m_locked = 0;
            end else begin
                d = $countones(3'(g ^ m_ref));
                if (d == 1) begin
                    if (b == (m_bin + 1) % 8) begin
                        x.up = 1; x.wrap = (m_bin == 7);
                        m_pos = (m_pos + 1) % 65536;
                    end else begin
                        x.dn = 1; x.wrap = (m_bin == 0) && (b == 7);
                        m_pos = (m_pos + 65535) % 65536;
                    end
                    m_ref = g; m_bin = b;
                    if (!m_locked) begin
                        m_steps++;
                        if (m_steps >= 2) m_locked = 1;
                    end
                end else if (d > 1) begin
                    x.err = 1; m_ref = g; m_bin = b; m_steps = 0; m_locked = 0;
`ifdef STV_GRAY_TRACKER_ERR_CNT_EN
                    if (m_ecnt < 255) m_ecnt++;
`endif
                end
            end
        end
        x.bin  = 3'(m_bin);
        x.pos  = 16'(m_pos);
        x.lock = m_locked;
        x.ecnt = 8'(m_ecnt);
        q.push_back(x);
    endtask

    // Monitor: every clock edge yields one observable output word
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (q.size() > 0) begin
            x = q.pop_front();
            n_total++;
            if (bin_out === x.bin && pos === x.pos && step_up === x.up &&
                step_dn === x.dn && wrap === x.wrap && err === x.err &&
                locked === x.lock && ecnt_act === x.ecnt) begin
                n_pass++;
            end else begin
                $display("FAIL outputs @%0t: got bin=%0d pos=%h up=%b dn=%b wrap=%b err=%b lock=%b ecnt=%0d required bin=%0d pos=%h up=%b dn=%b wrap=%b err=%b lock=%b ecnt=%0d",
                         $time, bin_out, pos, step_up, step_dn, wrap, err, locked, ecnt_act,
                         x.bin, x.pos, x.up, x.dn, x.wrap, x.err, x.lock, x.ecnt);
            end
        end
    end

    initial begin
        int r, g;
        model_reset();
        // 1: reset then idle
        cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0);
        // 2: acquire and lock on 000,001,011
        cyc(1, 0, 1, 0); cyc(1, 0, 1, 1); cyc(1, 0, 1, 3);
        // 3: climb to bin 7 then wrap to 0, repeat 0
        cyc(1, 0, 1, 2); cyc(1, 0, 1, 6); cyc(1, 0, 1, 7); cyc(1, 0, 1, 5); cyc(1, 0, 1, 4);
        cyc(1, 0, 1, 0); cyc(1, 0, 1, 0); cyc(1, 0, 0, 0);
        // 4: from pos 0 at 000 step down across the wrap
        cyc(1, 1, 0, 0);
        cyc(1, 0, 1, 0); cyc(1, 0, 1, 1); cyc(1, 0, 1, 0); cyc(1, 0, 1, 4);
        // 5: error at 001 -> 010, relock with two steps, then many errors
        cyc(1, 0, 1, 0); cyc(1, 0, 1, 1); cyc(1, 0, 1, 2);
        cyc(1, 0, 1, 3); cyc(1, 0, 1, 2); cyc(1, 0, 0, 0);
        for (int i = 0; i < 300; i++) cyc(1, 0, 1, (i % 2 == 0) ? 0 : 3);
        // 6: clear with en, async reset mid-sequence
        cyc(1, 0, 1, 1); cyc(1, 0, 1, 3);
        cyc(1, 1, 1, 2); cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 0); cyc(1, 0, 1, 1); cyc(1, 0, 1, 3);
        cyc(0, 0, 1, 2); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        // Random phase
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 50)      g = b2g((m_bin + 1) % 8);
            else if (r < 75) g = b2g((m_bin + 7) % 8);
            else if (r < 85) g = m_ref;
            else             g = $urandom_range(0, 7);
            if ($urandom_range(0, 499) == 0)      cyc(0, 0, 1, g);
            else if ($urandom_range(0, 99) == 0)  cyc(1, 1, $urandom_range(0, 1), g);
            else                                  cyc(1, 0, ($urandom_range(0, 3) != 0), g);
        end
        cyc(1, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        n_total++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d queued entries, required 0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
